serial_frame_receiver: RTL and testbench
========================================

# serial_frame_receiver

Header-decoding front end placed directly upstream of `transmitter_post`. Watches the idle-high serial line and detects a start bit. Shifts in a 2-bit destination port and an 8-bit payload length. Then issues a one-cycle `start` with the length on `parint`, so the transmitter's down-counter frames the payload bits that follow on the same `serial_in`. Tracks the payload itself and rejects new frames until the payload completes.

## Interface
- No parameters; all widths fixed.
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: synchronous, active-high reset.
- `serial_in` input 1: serial line; idle = 1, start bit = 0.
- `start` output 1: one-cycle pulse; drives transmitter `start`.
- `parint` output 8: captured payload length; drives transmitter `parint`.
- `port_num` output 2: captured destination port.
- `busy` output 1: high from start-bit detection until the payload ends.
- `frame_err` output 1: one-cycle pulse on a rejected header (parity build only; constant 0 otherwise).

## Operation
- State machine: IDLE, PORT, LEN, PAR (parity build only), XFER. One shift/bit counter (4 bits) and one payload counter (8 bits).
- **IDLE:** `serial_in`=0 at a posedge moves to PORT and clears the bit counter. A 1 stays in IDLE.
- **PORT:** samples 2 bits, MSB first, into the `port_num` shadow register. Moves to LEN after the 2nd bit.
- **LEN:** samples 8 bits, MSB first, into the length shadow register. After the 8th bit:
  - length = 0: discard the frame and return to IDLE; no `start`.
  - parity build: go to PAR.
  - otherwise: go to XFER, copy the shadows to `parint`/`port_num`, and load the payload counter with the length.
- **PAR:** samples 1 bit.
  - Even parity over port+length+parity bit: proceed as the length ≠ 0 case above.
  - Parity mismatch: return to IDLE, pulse `frame_err`, no `start`, outputs unchanged.
- **XFER:**
  - `start`=1 in the first XFER cycle only.
  - Counter decrements each cycle; leaves to IDLE on the posedge where it reaches 0, i.e. after exactly `length` payload cycles.
  - `serial_in` is not interpreted; a 0 during the payload is never taken as a start bit.
- `parint`/`port_num` change only on entry to XFER and hold until the next accepted frame.
- A mid-frame `rst` aborts immediately: no `start` issued and shadows discarded.

## Timing
- Posedge 0 samples the start bit. Port bits are sampled at edges 1–2, length bits at edges 3–10.
- **Non-parity build:**
  - `start` is high between edges 10 and 11, with `parint` already valid. This is the cycle the first payload bit is on `serial_in`.
  - Payload occupies edges 11 … 10+L.
  - `busy` is high from after edge 0 until after edge 10+L.
  - The earliest next start bit is sampled at edge 11+L (back-to-back supported).
- **Parity build:** parity is sampled at edge 11. Everything after it shifts by +1, so `start` is high between edges 11 and 12. `frame_err` is high between edges 11 and 12 on a mismatch.
- A zero-length frame drops `busy` after edge 10 (11 with parity).
- All outputs are registered.
- Reset values: `start`=0, `parint`=8'd0, `port_num`=2'd0, `busy`=0, `frame_err`=0, state IDLE, both counters 0.
- Length 255 is legal: 255 payload cycles, no wrap.

## Configuration
- `SERIAL_FRAME_PARITY_EN` defined:
  - PAR state present; the header carries an even-parity bit after the length.
  - A mismatch drops the frame and pulses `frame_err`.
  - `start` latency is +1 cycle.
- Undefined: no PAR state, `frame_err` tied to 0, timing as the non-parity build.

## Test plan
- **Basic frame:** idle 1s, then 0, port 2'b10, length 8'd5, then 5 payload bits → `start` one cycle between edges 10–11 with `parint`=5, `port_num`=2; `busy` drops after edge 15.
- **Back-to-back frames:** frame A (port 1, length 3) immediately followed by a start bit at edge 14 for frame B (port 3, length 200) → second `start` at edge 24–25 with `parint`=200, `port_num`=3; `parint` holds 3 until then.
- **Zero 0 in payload:** length 4 with payload 0000, followed by idle → no second frame detected; `busy` low after edge 14 and stays low.
- **Zero length:** header length 8'd0 → no `start`, `busy` low after edge 10, `parint` retains its prior value.
- **Reset mid-frame:** `rst` at edge 6 (mid-LEN), released, then a fresh frame (port 0, length 1) → `start` only for the fresh frame, `parint`=1; all outputs 0 during reset.
- **Parity build:** (`SERIAL_FRAME_PARITY_EN`) port 2'b01, length 8'h03, parity bit 1 → `start` between edges 11–12; same frame with parity 0 → `frame_err` pulse between edges 11–12, no `start`.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//
// Header-decoding front end for transmitter_post. Watches an idle-high serial
// line for a start bit (0). It then shifts in a 2-bit destination port and an
// 8-bit payload length, both MSB first. For a non-zero length it issues a
// one-cycle start pulse with the length on parint. The transmitter's
// down-counter then frames the payload bits that follow on the same line.
// While the payload is in flight the line is not interpreted, so a 0 in the
// payload is never taken as a new start bit.
//
// Optional feature macro: SERIAL_FRAME_PARITY_EN
//   Defined   : an even-parity bit follows the length. A mismatch drops the
//               frame and pulses frame_err. start arrives one cycle later.
//   Undefined : no parity bit, and frame_err is tied to 0.
//
// Ports
//   clk        in   1  single clock, all state changes on posedge
//   rst        in   1  synchronous active-high reset
//   serial_in  in   1  serial line (idle 1, start bit 0)
//   start      out  1  one-cycle pulse on entry to payload transfer
//   parint     out  8  captured payload length of the last accepted frame
//   port_num   out  2  captured destination port of the last accepted frame
//   busy       out  1  high from start-bit detection until payload end
//   frame_err  out  1  one-cycle pulse on a parity mismatch (parity build)
// -----------------------------------------------------------------------------
module serial_frame_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic       start,
    output logic [7:0] parint,
    output logic [1:0] port_num,
    output logic       busy,
    output logic       frame_err
);

`ifdef SERIAL_FRAME_PARITY_EN
    typedef enum logic [2:0] {IDLE, PORT, LEN, PAR, XFER} state_t;
`else
    typedef enum logic [2:0] {IDLE, PORT, LEN, XFER} state_t;
`endif

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] pay_cnt_reg, pay_cnt_next;
    logic [1:0] port_sh_reg, port_sh_next;
    logic [7:0] len_sh_reg, len_sh_next;
    logic       start_reg, start_next;
    logic [7:0] parint_reg, parint_next;
    logic [1:0] port_reg, port_next;
    logic       busy_reg, busy_next;
    logic       err_next;

    // The header-accept path is shared by LEN (non-parity) and PAR (parity).
    logic       accept;
    logic [7:0] accept_len;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        pay_cnt_next = pay_cnt_reg;
        port_sh_next = port_sh_reg;
        len_sh_next  = len_sh_reg;
        parint_next  = parint_reg;
        port_next    = port_reg;
        start_next   = 1'b0;
        err_next     = 1'b0;
        accept       = 1'b0;
        accept_len   = len_sh_reg;

        case (state_reg)
            IDLE: begin
                if (!serial_in) begin
                    state_next   = PORT;
                    bit_cnt_next = 4'd0;
                end
            end
            PORT: begin
                port_sh_next = {port_sh_reg[0], serial_in};
                if (bit_cnt_reg == 4'd1) begin
                    state_next   = LEN;
                    bit_cnt_next = 4'd0;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            LEN: begin
                len_sh_next = {len_sh_reg[6:0], serial_in};
                if (bit_cnt_reg == 4'd7) begin
                    bit_cnt_next = 4'd0;
`ifdef SERIAL_FRAME_PARITY_EN
                    // The zero-length check waits until parity is seen.
                    state_next = PAR;
`else
                    if (len_sh_next == 8'd0) begin
                        state_next = IDLE;
                    end else begin
                        accept     = 1'b1;
                        accept_len = len_sh_next;
                    end
`endif
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
`ifdef SERIAL_FRAME_PARITY_EN
            PAR: begin
                // Even parity: XOR over port, length and parity bit must be 0.
                if (^{port_sh_reg, len_sh_reg, serial_in}) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (len_sh_reg == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    accept     = 1'b1;
                    accept_len = len_sh_reg;
                end
            end
`endif
            XFER: begin
                // Loaded with L on entry, so IDLE is reached after L cycles.
                pay_cnt_next = pay_cnt_reg - 8'd1;
                if (pay_cnt_reg == 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (accept) begin
            state_next   = XFER;
            start_next   = 1'b1;
            parint_next  = accept_len;
            port_next    = port_sh_reg;
            pay_cnt_next = accept_len;
        end

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            pay_cnt_reg <= 8'd0;
            port_sh_reg <= 2'd0;
            len_sh_reg  <= 8'd0;
            start_reg   <= 1'b0;
            parint_reg  <= 8'd0;
            port_reg    <= 2'd0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            pay_cnt_reg <= pay_cnt_next;
            port_sh_reg <= port_sh_next;
            len_sh_reg  <= len_sh_next;
            start_reg   <= start_next;
            parint_reg  <= parint_next;
            port_reg    <= port_next;
            busy_reg    <= busy_next;
        end
    end

`ifdef SERIAL_FRAME_PARITY_EN
    logic err_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
    assign frame_err = err_reg;
`else
    logic err_unused;
    assign err_unused = err_next;
    assign frame_err  = 1'b0;
`endif

    assign start    = start_reg;
    assign parint   = parint_reg;
    assign port_num = port_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_receiver
//
// Directed frames are driven on serial_in. For each frame the stimulus pushes
// the expected start event (cycle, length, port) into a queue. In the parity
// build, frames with bad parity push an expected frame_err event instead. A
// monitor on the falling edge pops an entry whenever start or frame_err is seen
// and compares it. The stimulus also checks idle/busy and the output hold
// values at each start-bit boundary.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       start;
    logic [7:0] parint;
    logic [1:0] port_num;
    logic       busy;
    logic       frame_err;

    serial_frame_receiver dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .start     (start),
        .parint    (parint),
        .port_num  (port_num),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // cyc equals the index of the next posedge when read at a negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef SERIAL_FRAME_PARITY_EN
    localparam int START_SEEN = 12;
    localparam int PAR_BITS   = 1;
`else
    localparam int START_SEEN = 11;
    localparam int PAR_BITS   = 0;
`endif

    typedef struct {
        int         when;
        logic [7:0] len;
        logic [1:0] port;
    } exp_t;

    exp_t start_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   mon_w;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_parint;
    logic [1:0] exp_port;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every start / frame_err cycle must match a queued expectation.
    always @(negedge clk) begin
        if (start === 1'b1) begin
            if (start_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got start=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = start_q.pop_front();
                check("start_cycle", cyc, mon_e.when);
                check("start_parint", {24'd0, parint}, {24'd0, mon_e.len});
                check("start_port", {30'd0, port_num}, {30'd0, mon_e.port});
            end
        end
        if (frame_err !== 1'b0) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_err: got %b expected 0 (cycle %0d)", frame_err, cyc);
            end else begin
                mon_w = err_q.pop_front();
                check("frame_err_cycle", cyc, mon_w);
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_in = b;
    endtask

    // Drive one full frame: start bit, port, length, optional parity, payload.
    task automatic send_frame(input logic [1:0] p, input logic [7:0] l,
                              input logic pay, input logic par_flip);
        int   e0;
        logic ok;
        exp_t e;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("hold_parint", {24'd0, parint}, {24'd0, exp_parint});
        check("hold_port", {30'd0, port_num}, {30'd0, exp_port});
        e0 = cyc;
        serial_in = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
        ok = (l != 8'd0) && !par_flip;
        if (par_flip) err_q.push_back(e0 + 12);
`else
        ok = (l != 8'd0);
`endif
        if (ok) begin
            e.when = e0 + START_SEEN;
            e.len  = l;
            e.port = p;
            start_q.push_back(e);
        end
        send_bit(p[1]);
        check("hdr_busy", {31'd0, busy}, 32'd1);
        send_bit(p[0]);
        for (int i = 7; i >= 0; i--) send_bit(l[i]);
`ifdef SERIAL_FRAME_PARITY_EN
        send_bit((^{p, l}) ^ par_flip);
`endif
        if (ok) begin
            exp_parint = l;
            exp_port   = p;
            for (int i = 0; i < int'(l); i++) send_bit(pay);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1);
            check("idle_low", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst        = 1'b1;
        serial_in  = 1'b1;
        exp_parint = 8'd0;
        exp_port   = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_parint", {24'd0, parint}, 32'd0);
        check("rst_port", {30'd0, port_num}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (3) send_bit(1'b1);

        // Basic frame: port 2, length 5.
        send_frame(2'd2, 8'd5, 1'b1, 1'b0);
        send_bit(1'b1);

        // Back-to-back: A (port 1, len 3) then B (port 3, len 200, zero payload).
        send_frame(2'd1, 8'd3, 1'b1, 1'b0);
        send_frame(2'd3, 8'd200, 1'b0, 1'b0);

        // Zero payload bits must not be taken as a new start bit.
        send_frame(2'd0, 8'd4, 1'b0, 1'b0);
        idle_check(6);

        // Zero length: no start, outputs held (checked by the next frame).
        send_frame(2'd1, 8'd0, 1'b1, 1'b0);

        // Maximum length.
        send_frame(2'd2, 8'd255, 1'b1, 1'b0);
        send_bit(1'b1);

        // Reset in the middle of the length field.
        @(negedge clk);
        e0 = cyc;
        serial_in = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        check("abort_at_edge6", cyc, e0 + 6);
        rst = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        check("mid_rst_start", {31'd0, start}, 32'd0);
        check("mid_rst_parint", {24'd0, parint}, 32'd0);
        check("mid_rst_port", {30'd0, port_num}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        exp_parint = 8'd0;
        exp_port   = 2'd0;
        send_bit(1'b1);
        send_frame(2'd0, 8'd1, 1'b1, 1'b0);
        send_bit(1'b1);

`ifdef SERIAL_FRAME_PARITY_EN
        // Good parity, then the same header with the parity bit flipped.
        send_frame(2'd1, 8'h03, 1'b1, 1'b0);
        send_frame(2'd1, 8'h03, 1'b1, 1'b1);
        idle_check(2);
`endif

        idle_check(4);
        check("pending_start", start_q.size(), 32'd0);
        check("pending_frame_err", err_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
